mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 1, meaning: 1 = honour MemReady handshake; 0 = MemReady ignored, treated as 1.
REQ-002 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port op  in  7  opcode field of instruction register.
REQ-005 SHALL have port Zero  in  1  ALU zero flag.
REQ-006 SHALL have port MemReady  in  1  memory access completes this cycle.
REQ-007 SHALL have outputs, 1 bit each: PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal.
REQ-008 SHALL have outputs, 2 bits each: ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc.
REQ-009 SHALL have output instret  out  32  count of retired instructions.

Function
REQ-010 SHALL be a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL; every output not listed for a state is 0.
REQ-011 SHALL use encodings ALUSrcA 00=PC, 01=OldPC, 10=RD1; ALUSrcB 00=RD2, 01=ImmExt, 10=const 4; ResultSrc 00=ALUOut, 01=Data, 10=ALUResult; AdrSrc 0=PC, 1=Result; ALUOp 00=add, 01=sub, 10=funct-decoded.
REQ-012 SHALL drive PCWrite = PCUpdate | (Branch & Zero), where PCUpdate and Branch are internal state-decoded signals.
REQ-013 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PCUpdate=1 only when MemReady; goes to DECODE on MemReady, else stays.
REQ-014 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00; next state by op: 0000011/0100011 -> MEMADR, 0110011 -> EXECUTER, 0010011 -> EXECUTEI, 1100011 -> BEQ, 1101111 -> JAL; any other -> FETCH.
REQ-015 Illegal SHALL pulse 1 for exactly the DECODE cycle that sees an unsupported op; no register or memory write follows.
REQ-016 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; op 0000011 -> MEMREAD, else -> MEMWRITE.
REQ-017 MEMREAD: ResultSrc=00, AdrSrc=1; -> MEMWB on MemReady, else stays.
REQ-018 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-019 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held every cycle until MemReady; -> FETCH on MemReady.
REQ-020 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; both -> ALUWB.
REQ-021 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-022 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1; -> ALUWB.
REQ-023 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1; -> FETCH.
REQ-024 ImmSrc SHALL be combinational from op: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, other -> 00.
REQ-025 instret SHALL increment by 1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB or BEQ; it SHALL wrap 0xFFFFFFFF -> 0 and SHALL NOT increment on the illegal DECODE -> FETCH path.
REQ-026 Cycle counts with MemReady held 1 SHALL be: lw 5, sw 4, R/I-type 4, jal 4, beq 3.
REQ-027 With MEM_WAIT=0, FETCH, MEMREAD and MEMWRITE SHALL each last exactly one cycle regardless of MemReady.

Reset
REQ-028 While reset=1 at a rising edge, state SHALL become FETCH and instret SHALL become 0.
REQ-029 While reset=1, PCWrite, IRWrite, RegWrite, MemWrite and Illegal SHALL be forced 0, combinationally, regardless of state.
REQ-030 Reset asserted mid-instruction, including during a MEMWRITE stall, SHALL abort the instruction with no instret increment; FETCH SHALL begin on the first edge after reset deasserts.

Verification
REQ-031 Reset, then op=0000011, MemReady=1 -> state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB; RegWrite=1 with ResultSrc=01 in cycle 5; instret=1.
REQ-032 op=0100011, MemReady=0 for 3 cycles in MEMWRITE -> MemWrite=1 for 4 consecutive cycles, then FETCH; instret increments once.
REQ-033 op=1100011 with Zero=1 -> PCWrite=1 in BEQ; repeat with Zero=0 -> PCWrite=0 in BEQ; both return to FETCH after 3 cycles.
REQ-034 op=1111111 -> Illegal=1 for one cycle in DECODE, then FETCH; RegWrite and MemWrite stay 0; instret unchanged.
REQ-035 Preload instret to 0xFFFFFFFF via 2^32-1 retirements (or force), then execute op=0110011 -> instret=0 after ALUWB.
REQ-036 Assert reset during MEMREAD -> next cycle state is FETCH, all write enables 0, instret=0.

Source files
------------

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller -- multicycle RV32 subset control unit (Moore FSM).
//
// Sequences each instruction through FETCH/DECODE and a per-class execution
// path (load, store, R-type, I-type ALU, beq, jal), driving the datapath mux
// selects and write enables, and counts retired instructions.
//
// Parameters
//   MEM_WAIT   1: FETCH/MEMREAD/MEMWRITE wait for MemReady
//              0: MemReady ignored, memory phases take one cycle
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   op[6:0]    opcode from instruction register
//   Zero       ALU zero flag (beq)
//   MemReady   memory access completes this cycle
//   PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal   1-bit controls
//   ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc              2-bit selects
//   instret[31:0]  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mc_controller #(
    parameter int MEM_WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        Illegal,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ALUOp,
    output logic [1:0]  ImmSrc,
    output logic [31:0] instret
);

    // FSM state encodings
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    // Supported opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]  state_q, state_d;
    logic [31:0] instret_q, instret_d;

    logic ready;
    logic op_legal;
    logic retire;

    // Raw (pre-reset-gating) strobes decoded from the state
    logic pc_update, branch;
    logic ir_write_raw, reg_write_raw, mem_write_raw, illegal_raw;

    // With MEM_WAIT=0 every memory phase behaves as if it completed at once.
    assign ready = (MEM_WAIT == 0) ? 1'b1 : MemReady;

    assign op_legal = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
                      (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires when its final state hands back to FETCH. The
    // illegal DECODE->FETCH path is deliberately not in this list.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                     (state_q == S_ALUWB) || (state_q == S_BEQ));

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode (IRWrite/PCUpdate in FETCH also qualified by ready)
    // ------------------------------------------------------------------
    always_comb begin
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ALUOp         = 2'b00;
        case (state_q)
            S_FETCH: begin
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                ir_write_raw = ready;
                pc_update    = ready;
            end
            S_DECODE: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b01;
                illegal_raw = ~op_legal;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                branch  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format select depends only on the opcode
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Reset masks every architectural side effect immediately, so an
    // aborted instruction cannot write anything in the reset cycle.
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign Illegal  = ~reset & illegal_raw;
    assign instret  = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  op = 7'd0;
    logic        Zero = 1'b0;
    logic        MemReady = 1'b0;
    logic        tie0 = 1'b0;

    logic        PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal;
    logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
    logic [31:0] instret;

    logic        PCWrite1, AdrSrc1, IRWrite1, RegWrite1, MemWrite1, Illegal1;
    logic [1:0]  ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1;
    logic [31:0] instret1;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instret = 32'd0;

    always #5 clk = ~clk;

    mc_controller #(.MEM_WAIT(1)) dut (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemWrite(MemWrite), .Illegal(Illegal), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc),
        .instret(instret)
    );

    // Memory handshake ignored: MemReady tied low must not stall anything.
    mc_controller #(.MEM_WAIT(0)) dut_nw (
        .clk(clk), .reset(reset), .op(op), .Zero(Zero), .MemReady(tie0),
        .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .IRWrite(IRWrite1), .RegWrite(RegWrite1),
        .MemWrite(MemWrite1), .Illegal(Illegal1), .ResultSrc(ResultSrc1),
        .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1), .ALUOp(ALUOp1), .ImmSrc(ImmSrc1),
        .instret(instret1)
    );

    logic [15:0] v0, v1;
    assign v0 = {PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};
    assign v1 = {PCWrite1, AdrSrc1, IRWrite1, RegWrite1, MemWrite1, Illegal1,
                 ResultSrc1, ALUSrcA1, ALUSrcB1, ALUOp1, ImmSrc1};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                           IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    typedef enum {P_F, P_D, P_MA, P_MR, P_MWB, P_MW, P_ER, P_EI, P_AW, P_B, P_J} phase_e;
    typedef struct { phase_e ph; bit rdy; } step_t;
    step_t tr[$];

    function automatic bit legal(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    // Expected control word for one cycle of a given phase of an instruction.
    function automatic logic [15:0] exp_ctrl(input phase_e ph, input bit rdy,
                                             input bit z, input logic [6:0] o, input bit rst);
        logic pcw, adr, irw, rw, mw, ill;
        logic [1:0] rs, a, b, alu, imm;
        {pcw, adr, irw, rw, mw, ill} = 6'b0;
        {rs, a, b, alu} = 8'b0;
        imm = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        case (ph)
            P_F:   begin b = 2'b10; rs = 2'b10; irw = rdy; pcw = rdy; end
            P_D:   begin a = 2'b01; b = 2'b01; ill = !legal(o); end
            P_MA:  begin a = 2'b10; b = 2'b01; end
            P_MR:  adr = 1'b1;
            P_MWB: begin rs = 2'b01; rw = 1'b1; end
            P_MW:  begin adr = 1'b1; mw = 1'b1; end
            P_ER:  begin a = 2'b10; alu = 2'b10; end
            P_EI:  begin a = 2'b10; b = 2'b01; alu = 2'b10; end
            P_AW:  rw = 1'b1;
            P_B:   begin a = 2'b10; alu = 2'b01; pcw = z; end
            P_J:   begin a = 2'b01; b = 2'b10; pcw = 1'b1; end
            default: ;
        endcase
        if (rst) {pcw, irw, rw, mw, ill} = 5'b0;
        return {pcw, adr, irw, rw, mw, ill, rs, a, b, alu, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Memory phase: n cycles not ready (random 0..3 if n<0), then one ready.
    task automatic add_mem(input phase_e ph, input int n);
        int k = (n < 0) ? int'($urandom_range(0, 3)) : n;
        repeat (k) tr.push_back('{ph, 1'b0});
        tr.push_back('{ph, 1'b1});
    endtask

    task automatic add(input phase_e ph);
        tr.push_back('{ph, 1'($urandom)});
    endtask

    // Instruction-level trace from the opcode class.
    task automatic build(input logic [6:0] o, input int fs, input int ms);
        tr.delete();
        add_mem(P_F, fs);
        add(P_D);
        case (o)
            LW: begin add(P_MA); add_mem(P_MR, ms); add(P_MWB); end
            SW: begin add(P_MA); add_mem(P_MW, ms); end
            RT: begin add(P_ER); add(P_AW); end
            IT: begin add(P_EI); add(P_AW); end
            BQ: add(P_B);
            JL: begin add(P_J); add(P_AW); end
            default: ;
        endcase
    endtask

    // Run one instruction; abort_at >= 0 asserts reset at that trace step.
    // nw=1 checks the MEM_WAIT=0 instance with a stall-free trace.
    task automatic run_instr(input logic [6:0] o, input bit z, input int fs,
                             input int ms, input int abort_at, input bit nw);
        build(o, nw ? 0 : fs, nw ? 0 : ms);
        for (int i = 0; i < tr.size(); i++) begin
            @(negedge clk);
            reset = (i == abort_at);
            op = o; Zero = z;
            MemReady = nw ? 1'b0 : tr[i].rdy;
            #1;
            chk($sformatf("ctrl op=%b step=%0d ph=%s", o, i, tr[i].ph.name()),
                32'(nw ? v1 : v0), 32'(exp_ctrl(tr[i].ph, nw ? 1'b1 : tr[i].rdy, z, o, reset)));
            chk($sformatf("instret op=%b step=%0d", o, i), nw ? instret1 : instret, exp_instret);
            if (i == abort_at) begin
                @(negedge clk);
                MemReady = 1'b1;
                #1;
                exp_instret = 32'd0;
                chk("abort ctrl", 32'(v0), 32'(exp_ctrl(P_F, 1'b1, z, o, 1'b1)));
                chk("abort instret", instret, exp_instret);
                return;
            end
        end
        if (legal(o)) exp_instret++;
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            reset = 1'b1;
            MemReady = 1'($urandom);
            op = 7'($urandom);
            #1;
            if (k > 0) begin
                chk("reset ctrl", 32'(v0), 32'(exp_ctrl(P_F, MemReady, Zero, op, 1'b1)));
                chk("reset instret", instret, 32'd0);
                chk("reset instret nw", instret1, 32'd0);
            end
        end
        exp_instret = 32'd0;
    endtask

    initial begin
        logic [6:0] ops[7];
        ops = '{LW, SW, RT, IT, BQ, JL, 7'b1111111};

        // Reset then a stall-free load: 5 cycles, one retirement.
        do_reset(3);
        run_instr(LW, 1'b0, 0, 0, -1, 1'b0);
        // Store held 3 cycles in MEMWRITE by MemReady=0.
        run_instr(SW, 1'b0, 0, 3, -1, 1'b0);
        // beq taken and not taken.
        run_instr(BQ, 1'b1, 0, 0, -1, 1'b0);
        run_instr(BQ, 1'b0, 0, 0, -1, 1'b0);
        // Unsupported opcode: Illegal in DECODE, no retirement.
        run_instr(7'b1111111, 1'b0, 0, 0, -1, 1'b0);
        run_instr(JL, 1'b0, 0, 0, -1, 1'b0);
        run_instr(IT, 1'b0, 1, 0, -1, 1'b0);

        // Counter wrap: preload all-ones while FETCH stalls, then an R-type.
        do_reset(2);
        @(negedge clk);
        reset = 1'b0; MemReady = 1'b0;
        force dut.instret_q = 32'hFFFF_FFFF;
        #1 release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        run_instr(RT, 1'b0, 0, 0, -1, 1'b0);

        // Reset during MEMREAD (step 3) and during a MEMWRITE stall (step 4).
        run_instr(LW, 1'b0, 0, 0, 3, 1'b0);
        run_instr(SW, 1'b0, 0, 3, 4, 1'b0);

        // Randomized instruction stream with stalls and occasional aborts.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] o;
            int ab;
            o = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 6)];
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_instr(o, 1'($urandom), -1, -1, ab, 1'b0);
        end

        // MEM_WAIT=0 instance: memory phases never stall with MemReady low.
        do_reset(2);
        run_instr(LW, 1'b0, 0, 0, -1, 1'b1);
        run_instr(SW, 1'b0, 0, 0, -1, 1'b1);
        run_instr(RT, 1'b0, 0, 0, -1, 1'b1);

        @(negedge clk);
        #1;
        chk("final instret nw", instret1, exp_instret);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
